// File: rtl/csa_pipe_adder.sv
// Pipelined conditional-sum adder with valid/ready handshakes and a global stall.
// Define CSA_OVF_EN to add the pipelined signed-overflow output ovf.
module csa_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int G  = WIDTH / BLOCK;
  localparam int LV = $clog2(G);
  localparam int HF = WIDTH / 2;

  logic             en;
  logic [WIDTH-1:0] ye;
  logic             ce;
  logic [LV:0]      v_d;
  logic [LV:0]      v_q;

  // Operand conditioning for subtract, and the global stall enable.
  always_comb begin
    ye = sub ? ~y : y;
    ce = sub | cin;
    en = out_ready | ~v_q[LV];
  end

  assign in_ready  = en;
  assign out_valid = v_q[LV];

  // Valid bits shift together with the data, bubbles included.
  always_comb begin
    v_d = v_q;
    if (en) v_d = {v_q[LV-1:0], in_valid};
  end

  // Valid-bit register bank.
  always_ff @(posedge clk) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  for (genvar k = 0; k < LV; k++) begin : lv
    localparam int N  = G >> k;
    localparam int SW = BLOCK << k;
    localparam int H  = SW / 2;

    logic [WIDTH-1:0] s0_d, s0_q;
    logic [WIDTH-1:0] s1_d, s1_q;
    logic [N-1:0]     c0_d, c0_q;
    logic [N-1:0]     c1_d, c1_q;
    logic             ci_d, ci_q;
`ifdef CSA_OVF_EN
    logic             xm_d, xm_q;
    logic             ym_d, ym_q;
`endif

    if (k == 0) begin : g_leaf
      logic [BLOCK:0] t0;
      logic [BLOCK:0] t1;

      // Leaf groups: sum and carry for both carry-in hypotheses.
      always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        c0_d = c0_q;
        c1_d = c1_q;
        ci_d = ci_q;
        t0   = '0;
        t1   = '0;
`ifdef CSA_OVF_EN
        xm_d = xm_q;
        ym_d = ym_q;
`endif
        if (en) begin
          ci_d = ce;
          for (int g = 0; g < G; g++) begin
            t0 = {1'b0, x[g*BLOCK +: BLOCK]}
               + {1'b0, ye[g*BLOCK +: BLOCK]};
            t1 = t0 + (BLOCK+1)'(1);
            s0_d[g*BLOCK +: BLOCK] = t0[BLOCK-1:0];
            s1_d[g*BLOCK +: BLOCK] = t1[BLOCK-1:0];
            c0_d[g] = t0[BLOCK];
            c1_d[g] = t1[BLOCK];
          end
`ifdef CSA_OVF_EN
          xm_d = x[WIDTH-1];
          ym_d = ye[WIDTH-1];
`endif
        end
      end
    end else begin : g_merge
      // Merge pairs: lower carry picks the upper half, per hypothesis.
      always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        c0_d = c0_q;
        c1_d = c1_q;
        ci_d = ci_q;
`ifdef CSA_OVF_EN
        xm_d = xm_q;
        ym_d = ym_q;
`endif
        if (en) begin
          ci_d = lv[k-1].ci_q;
          for (int j = 0; j < N; j++) begin
            s0_d[j*SW +: H] = lv[k-1].s0_q[j*SW +: H];
            s1_d[j*SW +: H] = lv[k-1].s1_q[j*SW +: H];
            s0_d[j*SW+H +: H] = lv[k-1].c0_q[2*j]
                              ? lv[k-1].s1_q[j*SW+H +: H]
                              : lv[k-1].s0_q[j*SW+H +: H];
            s1_d[j*SW+H +: H] = lv[k-1].c1_q[2*j]
                              ? lv[k-1].s1_q[j*SW+H +: H]
                              : lv[k-1].s0_q[j*SW+H +: H];
            c0_d[j] = lv[k-1].c0_q[2*j]
                    ? lv[k-1].c1_q[2*j+1]
                    : lv[k-1].c0_q[2*j+1];
            c1_d[j] = lv[k-1].c1_q[2*j]
                    ? lv[k-1].c1_q[2*j+1]
                    : lv[k-1].c0_q[2*j+1];
          end
`ifdef CSA_OVF_EN
          xm_d = lv[k-1].xm_q;
          ym_d = lv[k-1].ym_q;
`endif
        end
      end
    end

    // Register bank after this level.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s0_q <= '0;
        s1_q <= '0;
        c0_q <= '0;
        c1_q <= '0;
        ci_q <= 1'b0;
`ifdef CSA_OVF_EN
        xm_q <= 1'b0;
        ym_q <= 1'b0;
`endif
      end else begin
        s0_q <= s0_d;
        s1_q <= s1_d;
        c0_q <= c0_d;
        c1_q <= c1_d;
        ci_q <= ci_d;
`ifdef CSA_OVF_EN
        xm_q <= xm_d;
        ym_q <= ym_d;
`endif
      end
    end
  end

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             csel;
`ifdef CSA_OVF_EN
  logic             ovf_d, ovf_q;
`endif

  // Last level: the true carry-in resolves the final halves.
  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    csel   = 1'b0;
`ifdef CSA_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (en) begin
      csel = lv[LV-1].ci_q ? lv[LV-1].c1_q[0] : lv[LV-1].c0_q[0];
      s_d[HF-1:0] = lv[LV-1].ci_q ? lv[LV-1].s1_q[HF-1:0]
                                  : lv[LV-1].s0_q[HF-1:0];
      s_d[WIDTH-1:HF] = csel ? lv[LV-1].s1_q[WIDTH-1:HF]
                             : lv[LV-1].s0_q[WIDTH-1:HF];
      cout_d = csel ? lv[LV-1].c1_q[1] : lv[LV-1].c0_q[1];
`ifdef CSA_OVF_EN
      ovf_d = s_d[WIDTH-1] ^ lv[LV-1].xm_q
            ^ lv[LV-1].ym_q ^ cout_d;
`endif
    end
  end

  // Output register bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
`ifdef CSA_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
`ifdef CSA_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
`ifdef CSA_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder: directed cases, stall, mid-pipe reset, random run.
// Results are checked against a queue of golden values pushed on acceptance.
module tb_csa_pipe_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         in_ready;
  logic         out_valid;
  logic         cout;
  logic [W-1:0] s;
  logic         ovf_w;

  csa_pipe_adder #(.WIDTH(W), .BLOCK(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x(x),
    .y(y),
    .cin(cin),
    .sub(sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s(s),
    .cout(cout)
`ifdef CSA_OVF_EN
    ,
    .ovf(ovf_w)
`endif
  );

`ifndef CSA_OVF_EN
  assign ovf_w = 1'b0;
`endif

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_recv = 0;
  logic [17:0] sb[$];
  logic        stall_p = 1'b0;
  logic [17:0] held = '0;
  logic [17:0] cur;
  logic [17:0] exp_v;

  assign cur = {ovf_w, cout, s};

  function automatic logic [17:0] gold(logic [15:0] a, logic [15:0] b,
                                       logic ci, logic sb_i);
    logic [15:0] be;
    logic [16:0] r;
    logic        ov;
    be = sb_i ? ~b : b;
    r  = {1'b0, a} + {1'b0, be} + 17'(sb_i | ci);
    ov = (a[15] == be[15]) && (r[15] != a[15]);
`ifndef CSA_OVF_EN
    ov = 1'b0;
`endif
    return {ov, r};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on retire, hold on stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        check("hold_valid", 32'(out_valid), 32'(1));
        check("hold_data", 32'(cur), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("extra_result", 32'(out_valid), 32'(0));
        end else begin
          exp_v = sb.pop_front();
          check("result", 32'(cur), 32'(exp_v));
          n_recv++;
        end
      end
      if (in_valid && in_ready) sb.push_back(gold(x, y, cin, sub));
      stall_p = out_valid && !out_ready;
      held = cur;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [15:0] a, logic [15:0] b,
                       logic c, logic sb_i);
    in_valid = v;
    x = a;
    y = b;
    cin = c;
    sub = sb_i;
  endtask

  task automatic directed(string tag, logic [15:0] a, logic [15:0] b,
                          logic c, logic sb_i, logic [15:0] es,
                          logic ec, logic eo);
    out_ready = 1'b1;
    drive(1'b1, a, b, c, sb_i);
    cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    cyc();
    check({tag, "_early"}, 32'(out_valid), 32'(0));
    cyc();
    check({tag, "_valid"}, 32'(out_valid), 32'(1));
    check({tag, "_s"}, 32'(s), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef CSA_OVF_EN
    check({tag, "_ovf"}, 32'(ovf_w), 32'(eo));
`else
    if (eo) check({tag, "_ovf"}, 32'(ovf_w), 32'(0));
`endif
    cyc();
  endtask

  logic [15:0] ca, cb;
  logic        cc, cs, acc, seen;
  int          sent, stallc, start;

  task automatic new_op();
    ca = 16'($urandom);
    cb = 16'($urandom);
    cc = 1'($urandom);
    cs = 1'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    cyc();
    cyc();
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_s", 32'(s), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
    check("rst_ovf", 32'(ovf_w), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    rst_n = 1'b1;
    cyc();

    directed("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    directed("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Back-pressure: six ops, consumer stalls 3 cycles at first result.
    start = n_recv;
    sent = 0;
    stallc = 0;
    seen = 1'b0;
    new_op();
    for (int t = 0; t < 60; t++) begin
      if (sent == 6 && sb.size() == 0) break;
      if (out_valid && !seen) begin
        seen = 1'b1;
        stallc = 3;
      end
      out_ready = (stallc == 0);
      drive(sent < 6, ca, cb, cc, cs);
      #1;
      if (stallc > 0) begin
        check("bp_in_ready", 32'(in_ready), 32'(0));
        stallc--;
      end
      acc = in_valid && in_ready;
      cyc();
      if (acc) begin
        sent++;
        new_op();
      end
    end
    in_valid = 1'b0;
    check("bp_count", 32'(n_recv - start), 32'(6));
    check("bp_empty", 32'(sb.size()), 32'(0));

    // Reset with three operations in flight.
    start = n_recv;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_op();
      drive(1'b1, ca, cb, cc, cs);
      cyc();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    check("mid_rst_s", 32'(s), 32'(0));
    rst_n = 1'b1;
    repeat (8) cyc();
    check("mid_rst_none", 32'(n_recv - start), 32'(0));

    // Random regression with random back-pressure.
    start = n_recv;
    sent = 0;
    new_op();
    for (int t = 0; t < 60000; t++) begin
      if (sent == 10000 && sb.size() == 0) break;
      out_ready = ($urandom_range(0, 3) != 0);
      drive((sent < 10000) && ($urandom_range(0, 4) != 0), ca, cb, cc, cs);
      #1;
      acc = in_valid && in_ready;
      cyc();
      if (acc) begin
        sent++;
        new_op();
      end
    end
    in_valid = 1'b0;
    check("rnd_count", 32'(n_recv - start), 32'(10000));
    check("rnd_empty", 32'(sb.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csa_pipe_adder.md
# csa_pipe_adder

Parametrised, pipelined conditional-sum adder with valid/ready handshaking on both sides. Each operand is split into `BLOCK`-bit groups. Every group computes its sum for carry-in 0 and for carry-in 1. Pairs of groups are then merged level by level, with one register stage per merge level. The block serves as the wide-operand add/subtract unit in the datapath, replacing fixed 8-bit combinational adders.

## Interface
Parameters:
- `WIDTH`, 16, operand and sum width. `WIDTH/BLOCK` must be a power of two ≥ 2.
- `BLOCK`, 2, width of a leaf conditional-sum group.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `in_valid`  input  1  operand set presented.
- `in_ready`  output  1  block accepts operands this cycle.
- `x`  input  WIDTH  operand A.
- `y`  input  WIDTH  operand B.
- `cin`  input  1  carry-in.
- `sub`  input  1  1 = compute x − y; y is inverted and the effective carry-in is forced to 1; `cin` is ignored.
- `out_valid`  output  1  result presented.
- `out_ready`  input  1  consumer accepts result.
- `s`  output  WIDTH  sum.
- `cout`  output  1  carry-out; in subtract mode, 1 means no borrow.
- `ovf`  output  1  signed overflow; present only with `CSA_OVF_EN`.

## Operation
- Levels: L = log2(WIDTH/BLOCK) + 1.
  - Level 0 is the leaf stage. It computes `{c0,s0}` and `{c1,s1}` per group, for group carry-in 0 and 1.
  - Level k (k ≥ 1) merges adjacent pairs. The upper pair's sum and carry are selected by the lower pair's carry, separately for both carry-in hypotheses.
  - At the last level, the true carry-in selects the final `{cout,s}`.
- The effective carry-in (`cin`, or 1 when `sub`=1) and the operands travel with their data through the pipe.
- There is one register bank after each level, plus a valid bit per stage.
- Stall rule: global enable `en = out_ready | ~out_valid`.
  - `in_ready = en`.
  - When `en`=1, every stage shifts forward one position, including bubbles.
  - When `en`=0, all stages hold their data and valid bits unchanged.
- An operand set is accepted on any edge where `in_valid & in_ready`. Otherwise stage 0 loads valid=0.
- Result width is exactly `WIDTH`. The carry beyond MSB goes to `cout` only; there is no saturation.

## Timing
- Latency: L cycles from acceptance to `out_valid`. The default parameters give L=4.
- Throughput: one result per cycle when `out_ready` is held high.
- Reset (`rst_n`=0 at an edge):
  - All stage valid bits clear.
  - `out_valid`=0, `s`=0, `cout`=0, `ovf`=0.
  - `in_ready`=1 starting the cycle after reset.
  - In-flight operations are discarded, even if reset asserts mid-pipe.
- Output stability: while `out_valid & ~out_ready`, `s`, `cout` and `ovf` must not change.
- Simultaneous accept and retire in the same cycle is legal. The pipe shifts and no data is lost or duplicated.
- `in_ready` is combinational from `out_ready` and `out_valid`. It has no path from `in_valid`.

## Configuration
- `CSA_OVF_EN` defined:
  - Adds the `ovf` output, computed as carry-into-MSB XOR carry-out-of-MSB.
  - `ovf` is pipelined alongside `s` with the same latency and the same reset value (0).
- `CSA_OVF_EN` undefined:
  - The `ovf` port and its logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=16, BLOCK=2.
- Basic add: accept x=0x1234, y=0x4321, cin=0, sub=0 with `out_ready`=1 → 4 cycles later `out_valid`=1, s=0x5555, cout=0.
- Carry ripple across all groups: x=0xFFFF, y=0x0000, cin=1 → s=0x0000, cout=1.
- Subtract with borrow: x=0x0003, y=0x0005, sub=1 → s=0xFFFE, cout=0. With `CSA_OVF_EN`, the case x=0x7FFF, y=0x0001, sub=0 → s=0x8000, ovf=1.
- Back-pressure:
  - Stream 6 random operations back-to-back while `out_ready`=0 for 3 cycles after the first `out_valid`.
  - `in_ready` must drop while the pipe is stalled.
  - No result is lost or duplicated, order is preserved, and `s` is stable while stalled.
- Reset mid-operation: assert `rst_n`=0 for 1 cycle while 3 operations are in flight → `out_valid`=0 and `s`=0 after the edge. None of the 3 results ever appears.
- Random regression: 10,000 random x, y, cin, sub values with random `out_ready` → every result matches the golden model `{cout,s} = x + (sub ? ~y : y) + (sub ? 1 : cin)`.
